// File: rtl/flex_fifo.sv
// flex_fifo: synchronous FIFO with selectable read mode.
//   FWFT = 0 : registered read, data_o/valid_o update one cycle after an accepted read.
//   FWFT = 1 : first-word-fall-through, data_o shows the head entry, valid_o = !empty_o.
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   wr_en_i, data_i        write request and payload
//   rd_en_i                read request (pop/acknowledge in FWFT mode)
//   clr_err_i              clears the sticky overflow/underflow flags
//   data_o, valid_o        read data and its qualifier
//   count_o                occupancy 0..DEPTH
//   full_o, empty_o, almost_full_o, almost_empty_o  status flags
//   overflow_o, underflow_o                         sticky error flags
module flex_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 2,
  parameter int FWFT        = 0,
  parameter int AF_THR      = (2 ** DEPTH_WIDTH) - 1,
  parameter int AE_THR      = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   rd_en_i,
  input  logic                   clr_err_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   valid_o,
  output logic [DEPTH_WIDTH:0]   count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int PW = DEPTH_WIDTH + 1;
  localparam int DEPTH = 2 ** DEPTH_WIDTH;
  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C     = PW'(AF_THR);
  localparam logic [PW-1:0] AE_C     = PW'(AE_THR);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  if ((AE_THR < 0) || (AE_THR >= AF_THR) || (AF_THR > DEPTH)) begin : g_thr_bad
    $fatal(1, "flex_fifo: thresholds must satisfy 0 <= AE_THR < AF_THR <= DEPTH");
  end

  logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic                   overflow_r;
  logic                   underflow_r;

  logic [PW-1:0]          count_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   wr_acc_s;
  logic                   rd_acc_s;
  logic                   ovf_set_s;
  logic                   unf_set_s;
  logic [DEPTH_WIDTH-1:0] wr_idx_s;
  logic [DEPTH_WIDTH-1:0] rd_idx_s;

  // Occupancy, status and acceptance decode from the registered pointers
  always_comb begin
    count_s   = wr_ptr_r - rd_ptr_r;
    full_s    = (count_s == DEPTH_C);
    empty_s   = (count_s == PTR_ZERO);
    // At full a simultaneous read frees the head slot, so the write passes through
    wr_acc_s  = wr_en_i && (!full_s || rd_en_i);
    rd_acc_s  = rd_en_i && !empty_s;
    ovf_set_s = wr_en_i && full_s && !rd_en_i;
    unf_set_s = rd_en_i && empty_s;
    wr_idx_s  = wr_ptr_r[DEPTH_WIDTH-1:0];
    rd_idx_s  = rd_ptr_r[DEPTH_WIDTH-1:0];
  end

  assign count_o        = count_s;
  assign full_o         = full_s;
  assign empty_o        = empty_s;
  assign almost_full_o  = (count_s >= AF_C);
  assign almost_empty_o = (count_s <= AE_C);
  assign overflow_o     = overflow_r;
  assign underflow_o    = underflow_r;

  // Pointer advance and sticky error flags; a set event beats a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      overflow_r  <= ovf_set_s | (overflow_r  & ~clr_err_i);
      underflow_r <= unf_set_s | (underflow_r & ~clr_err_i);
    end
  end

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_r[wr_idx_s] <= data_i;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_o  = mem_r[rd_idx_s];
    assign valid_o = !empty_s;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;

    // Registered read port: capture the head on an accepted read, pulse valid once
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_r  <= {DATA_WIDTH{1'b0}};
        valid_r <= 1'b0;
      end else begin
        if (rd_acc_s) begin
          data_r <= mem_r[rd_idx_s];
        end
        valid_r <= rd_acc_s;
      end
    end

    assign data_o  = data_r;
    assign valid_o = valid_r;
  end

endmodule

// File: tb/tb_flex_fifo.sv
// Self-checking bench for flex_fifo: one registered-read instance (u_reg) driven
// through a queue-based reference model, one FWFT instance (u_fwft) with directed checks.
module tb_flex_fifo;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;

  logic       wr_en, rd_en, clr_err;
  logic [7:0] wdata;
  logic [7:0] data_o;
  logic       valid_o, full_o, empty_o, af_o, ae_o, ovf_o, unf_o;
  logic [2:0] count_o;

  logic       wr1, rd1, clr1;
  logic [7:0] wdata1;
  logic [7:0] data1;
  logic       valid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0] count1;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] mq[$];
  logic [7:0] out_q[$];
  logic [7:0] q1[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_data = 8'h00;

  always #5 clk_i = ~clk_i;

  flex_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(2), .FWFT(0)) u_reg (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en), .data_i(wdata),
    .rd_en_i(rd_en), .clr_err_i(clr_err), .data_o(data_o), .valid_o(valid_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(af_o), .almost_empty_o(ae_o),
    .overflow_o(ovf_o), .underflow_o(unf_o)
  );

  flex_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(2), .FWFT(1)) u_fwft (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr1), .data_i(wdata1),
    .rd_en_i(rd1), .clr_err_i(clr1), .data_o(data1), .valid_o(valid1),
    .count_o(count1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(af1), .almost_empty_o(ae1),
    .overflow_o(ovf1), .underflow_o(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Status of the registered-read instance against the model occupancy
  task automatic check_status();
    int n;
    n = mq.size();
    chk("count", 32'(count_o), 32'(n));
    chk("empty", 32'(empty_o), 32'(n == 0));
    chk("full",  32'(full_o),  32'(n == 4));
    chk("afull", 32'(af_o),    32'(n >= 3));
    chk("aempty", 32'(ae_o),   32'(n <= 1));
    chk("overflow",  32'(ovf_o), 32'(m_ovf));
    chk("underflow", 32'(unf_o), 32'(m_unf));
  endtask

  // One clock of stimulus on u_reg; the model predicts acceptance and results
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    logic m_full, m_empty, wacc, racc;
    m_full  = (mq.size() == 4);
    m_empty = (mq.size() == 0);
    wacc = wr && (!m_full || rd);
    racc = rd && !m_empty;
    wr_en = wr; wdata = d; rd_en = rd; clr_err = clr;
    if (racc) begin
      m_data = mq.pop_front();
      out_q.push_back(m_data);
    end
    if (wacc) mq.push_back(d);
    m_ovf = (wr && m_full && !rd) | (m_ovf & !clr);
    m_unf = (rd && m_empty) | (m_unf & !clr);
    @(posedge clk_i); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    chk("valid", 32'(valid_o), 32'(racc));
    if (valid_o) begin
      if (out_q.size() > 0) chk("rdata", 32'(data_o), 32'(out_q.pop_front()));
      else chk("rdata_unexpected", 32'(1), 32'(0));
    end else begin
      out_q.delete();
      chk("data_hold", 32'(data_o), 32'(m_data));
    end
    check_status();
  endtask

  // One clock of stimulus on u_fwft
  task automatic step1(input logic wr, input logic [7:0] d, input logic rd);
    wr1 = wr; wdata1 = d; rd1 = rd; clr1 = 1'b0;
    @(posedge clk_i); #1;
    wr1 = 1'b0; rd1 = 1'b0;
  endtask

  initial begin
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0; wdata1 = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    // Reset state
    check_status();
    chk("rst_valid", 32'(valid_o), 32'(0));
    chk("rst_data",  32'(data_o),  32'(0));
    chk("rst_fwft_empty", 32'(empty1), 32'(1));
    chk("rst_fwft_valid", 32'(valid1), 32'(0));
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Fill with four words, then drain in order
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow on a full FIFO, clear it, original data survives
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Pass-through at full: simultaneous read/write for six cycles wraps pointers
    for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow, and a set event beating a same-cycle clear
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Empty with both requests: write accepted, read rejected
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 10));
    end

    // Asynchronous reset mid-operation with three entries stored
    while (mq.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    mq.delete(); out_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_data = 8'h00;
    check_status();
    chk("arst_valid", 32'(valid_o), 32'(0));
    chk("arst_data",  32'(data_o),  32'(0));
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // FWFT instance: written word falls through without a read
    step1(1'b1, 8'hA5, 1'b0);
    chk("fwft_data", 32'(data1), 32'(8'hA5));
    chk("fwft_valid", 32'(valid1), 32'(1));
    chk("fwft_count", 32'(count1), 32'(1));
    step1(1'b0, 8'h00, 1'b0);
    chk("fwft_hold", 32'(data1), 32'(8'hA5));
    step1(1'b0, 8'h00, 1'b1);
    chk("fwft_pop_valid", 32'(valid1), 32'(0));
    chk("fwft_pop_empty", 32'(empty1), 32'(1));
    for (int i = 0; i < 3; i++) begin
      step1(1'b1, 8'hD1 + 8'(i), 1'b0);
      q1.push_back(8'hD1 + 8'(i));
    end
    chk("fwft_count3", 32'(count1), 32'(3));
    while (q1.size() > 0) begin
      chk("fwft_head_valid", 32'(valid1), 32'(1));
      chk("fwft_head", 32'(data1), 32'(q1.pop_front()));
      step1(1'b0, 8'h00, 1'b1);
    end
    chk("fwft_drained", 32'(empty1), 32'(1));
    step1(1'b1, 8'hC7, 1'b1);
    chk("fwft_both_data", 32'(data1), 32'(8'hC7));
    chk("fwft_both_count", 32'(count1), 32'(1));
    chk("fwft_both_unf", 32'(unf1), 32'(1));
    chk("fwft_no_ovf", 32'(ovf1), 32'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flex_fifo.md
FLEX_FIFO -- requirements
Module: flex_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 2; storage depth DEPTH = 2**DEPTH_WIDTH entries, all usable.
REQ-003 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AF_THR, default DEPTH-1, almost-full threshold in entries.
REQ-005 SHALL have parameter AE_THR, default 1, almost-empty threshold in entries.
REQ-006 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port wr_en_i  input  1  write request.
REQ-009 SHALL have port data_i  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rd_en_i  input  1  read request.
REQ-011 SHALL have port clr_err_i  input  1  clears sticky error flags.
REQ-012 SHALL have port data_o  output  DATA_WIDTH  read data.
REQ-013 SHALL have port valid_o  output  1  data_o holds valid read data.
REQ-014 SHALL have port count_o  output  DEPTH_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports full_o, empty_o, almost_full_o, almost_empty_o  output  1 each  status flags.
REQ-016 SHALL have ports overflow_o, underflow_o  output  1 each  sticky error flags.

Function
REQ-017 SHALL keep write and read pointers of DEPTH_WIDTH+1 bits; low DEPTH_WIDTH bits address storage, MSB distinguishes wrap; pointers wrap modulo 2*DEPTH.
REQ-018 SHALL drive count_o = wr_ptr - rd_ptr (modulo 2*DEPTH), combinationally from registered pointers.
REQ-019 SHALL assert empty_o iff count_o == 0 and full_o iff count_o == DEPTH; never both.
REQ-020 SHALL assert almost_full_o iff count_o >= AF_THR and almost_empty_o iff count_o <= AE_THR.
REQ-021 SHALL accept a write when wr_en_i && (!full_o || rd_en_i); accepted write stores data_i at wr_ptr and increments wr_ptr.
REQ-022 SHALL accept a read when rd_en_i && !empty_o; accepted read increments rd_ptr.
REQ-023 Simultaneous accepted read and write SHALL leave count_o unchanged, including at full (pass-through: head read out, new entry stored at freed slot).
REQ-024 With empty_o and both requests: write accepted, read rejected; in FWFT=1 the written word appears on data_o the next cycle.
REQ-025 FWFT=0: on accepted read, data_o SHALL load storage[rd_ptr] at that edge (1-cycle latency) and valid_o SHALL be 1 for exactly the following cycle; otherwise data_o holds and valid_o = 0.
REQ-026 FWFT=1: data_o SHALL combinationally show storage[rd_ptr] and valid_o SHALL equal !empty_o; rd_en_i acts as pop/acknowledge.
REQ-027 Rejected write (wr_en_i && full_o && !rd_en_i) SHALL set overflow_o at that edge; data not stored, wr_ptr unchanged.
REQ-028 Rejected read (rd_en_i && empty_o) SHALL set underflow_o at that edge; rd_ptr, data_o unchanged.
REQ-029 overflow_o and underflow_o SHALL be sticky until clr_err_i is sampled high; a set event in the same cycle as clr_err_i SHALL win (flag stays 1).
REQ-030 Thresholds SHALL satisfy 0 <= AE_THR < AF_THR <= DEPTH; elaboration-time check fails otherwise.

Reset
REQ-031 rst_ni low SHALL immediately clear both pointers, data_o, valid_o, overflow_o, underflow_o; hence count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
REQ-032 Storage contents SHALL NOT require reset; reset mid-operation discards all stored entries.
REQ-033 First accepted operation SHALL be possible on the first rising edge after rst_ni deasserts.

Verification (DATA_WIDTH=8, DEPTH_WIDTH=2, defaults unless stated)
REQ-034 FWFT=0: write 0x11,0x22,0x33,0x44 -> count_o 1..4, full_o=1 after 4th; four reads -> data_o 0x11,0x22,0x33,0x44 each one cycle after its read with valid_o=1, then empty_o=1.
REQ-035 Full FIFO, wr_en_i only with 0x55 -> overflow_o=1, count_o stays 4, subsequent reads return original data; clr_err_i pulse -> overflow_o=0.
REQ-036 Full FIFO, wr_en_i=rd_en_i=1 with 0x66 for 6 cycles -> count_o stays 4, no overflow, pointers wrap; drain returns last four written words in order.
REQ-037 Empty FIFO, rd_en_i only -> underflow_o=1, data_o unchanged; same cycle clr_err_i=1 and another rejected read -> underflow_o remains 1.
REQ-038 FWFT=1: write 0xA5 into empty FIFO -> next cycle data_o=0xA5, valid_o=1 without rd_en_i; pop -> valid_o=0, empty_o=1.
REQ-039 Three entries stored, rst_ni pulsed low between edges -> count_o=0, empty_o=1, flags 0 immediately; next write/read returns the new word only.
